// File: rtl/mtx_serializer.sv
// mtx_serializer: buffers packets and slices them into framed beats of a selectable width
module mtx_serializer #(
  parameter int PW = 104,
  parameter int IOW = 64,
  parameter int DEPTH = 4,
  parameter int PROG_FULL = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tx_en,
  input  logic           lsbfirst,
  input  logic [1:0]     iowidth,
  input  logic           access_in,
  input  logic [PW-1:0]  packet_in,
  output logic           wait_out,
  output logic           tx_access,
  output logic [IOW-1:0] tx_packet,
  output logic           tx_last,
  input  logic           tx_wait,
  output logic           tx_empty,
  output logic           tx_full,
  output logic           tx_prog_full
);
  localparam int SW = ((PW + IOW - 1) / IOW) * IOW;
  localparam int W0 = 8;
  localparam int W1 = IOW < 16 ? IOW : 16;
  localparam int W2 = IOW < 32 ? IOW : 32;
  localparam int W3 = IOW < 64 ? IOW : 64;
  localparam int B0 = (PW + W0 - 1) / W0;
  localparam int B1 = (PW + W1 - 1) / W1;
  localparam int B2 = (PW + W2 - 1) / W2;
  localparam int B3 = (PW + W3 - 1) / W3;
  localparam int CW = $clog2(B0 + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [OW-1:0] occ, occ_n;
  logic [SW-1:0] sr, src, nsr, nb;
  logic [IOW-1:0] tp;
  logic [CW-1:0] cnt;
  logic [1:0] sel, s;
  logic lsb, f, push, ld, adv;
  int w, b;
  // Handshake, load decision and next beat; width/order come from the inputs only when loading
  always_comb begin
    push = access_in && !wait_out;
    ld = (occ != '0) && tx_en && (state == IDLE || (!tx_wait && cnt == '0));
    adv = state == SEND && !tx_wait && cnt != '0;
    state_n = ld ? SEND : (state == SEND && !tx_wait && cnt == '0) ? IDLE : state;
    occ_n = occ + OW'(push) - OW'(ld);
    s = ld ? iowidth : sel;
    f = ld ? lsbfirst : lsb;
    w = s == 2'd0 ? W0 : s == 2'd1 ? W1 : s == 2'd2 ? W2 : W3;
    b = s == 2'd0 ? B0 : s == 2'd1 ? B1 : s == 2'd2 ? B2 : B3;
    src = !ld ? sr : lsbfirst ? SW'(mem[rp]) : SW'(mem[rp]) << (SW - b * w);
    nb = f ? src : src >> (SW - w);
    nsr = f ? src >> w : src << w;
    tp = nb[IOW-1:0] & ({IOW{1'b1}} >> (IOW - w));
  end
  // Packet storage, written on every accepted push
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= packet_in;
  end
  // Pointers, occupancy and status flags registered from the next occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      occ <= '0;
      wait_out <= 1'b0;
      tx_full <= 1'b0;
      tx_prog_full <= 1'b0;
      tx_empty <= 1'b1;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (ld) rp <= rp + 1'b1;
      occ <= occ_n;
      wait_out <= occ_n == OW'(DEPTH);
      tx_full <= occ_n == OW'(DEPTH);
      tx_prog_full <= occ_n >= OW'(PROG_FULL);
      tx_empty <= occ_n == '0 && state_n == IDLE;
    end
  end
  // Serializer FSM: load, advance or hold beats with registered framing
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tx_access <= 1'b0;
      tx_last <= 1'b0;
      tx_packet <= '0;
      sr <= '0;
      cnt <= '0;
      sel <= '0;
      lsb <= 1'b0;
    end else begin
      state <= state_n;
      if (ld) begin
        tx_access <= 1'b1;
        tx_packet <= tp;
        sr <= nsr;
        cnt <= CW'(b - 1);
        tx_last <= b == 1;
        sel <= iowidth;
        lsb <= lsbfirst;
      end else if (adv) begin
        tx_packet <= tp;
        sr <= nsr;
        cnt <= cnt - 1'b1;
        tx_last <= cnt == CW'(1);
      end else if (state_n == IDLE) begin
        tx_access <= 1'b0;
        tx_last <= 1'b0;
        tx_packet <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mtx_serializer.sv
// tb_mtx_serializer: directed vector table plus corner-case sequences for mtx_serializer
module tb_mtx_serializer;
  logic clk = 1'b0, reset, tx_en, lsbfirst, access_in, tx_wait;
  logic [1:0] iowidth;
  logic [103:0] packet_in;
  logic wait_out, tx_access, tx_last, tx_empty, tx_full, tx_prog_full;
  logic [63:0] tx_packet;
  int total = 0, bad = 0;
  localparam logic [103:0] P = 104'h0123456789ABCDEF0011223344;
  typedef struct {
    logic [1:0] iow;
    logic lsb;
    int n;
    logic [0:12][63:0] b;
  } vec_t;
  vec_t vt[6];

  mtx_serializer dut (
    .clk(clk), .reset(reset), .tx_en(tx_en), .lsbfirst(lsbfirst), .iowidth(iowidth),
    .access_in(access_in), .packet_in(packet_in), .wait_out(wait_out),
    .tx_access(tx_access), .tx_packet(tx_packet), .tx_last(tx_last), .tx_wait(tx_wait),
    .tx_empty(tx_empty), .tx_full(tx_full), .tx_prog_full(tx_prog_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [103:0] pk(input int i);
    return {40'hA0 + 40'(i), 64'h1000 + 64'(i)};
  endfunction

  initial begin
    int acc;
    logic [127:0] q;
    logic [63:0] fp;
    logic fa, fl;
    vt[0] = '{2'd0, 1'b1, 13, {64'h44, 64'h33, 64'h22, 64'h11, 64'h00, 64'hEF, 64'hCD,
                               64'hAB, 64'h89, 64'h67, 64'h45, 64'h23, 64'h01}};
    vt[1] = '{2'd3, 1'b0, 2, {64'h0000000123456789, 64'hABCDEF0011223344, {11{64'h0}}}};
    vt[2] = '{2'd2, 1'b0, 4, {64'h00000001, 64'h23456789, 64'hABCDEF00, 64'h11223344,
                              {9{64'h0}}}};
    vt[3] = '{2'd1, 1'b1, 7, {64'h3344, 64'h1122, 64'hEF00, 64'hABCD, 64'h6789, 64'h2345,
                              64'h0001, {6{64'h0}}}};
    vt[4] = '{2'd0, 1'b0, 13, {64'h01, 64'h23, 64'h45, 64'h67, 64'h89, 64'hAB, 64'hCD,
                               64'hEF, 64'h00, 64'h11, 64'h22, 64'h33, 64'h44}};
    vt[5] = '{2'd3, 1'b1, 2, {64'hABCDEF0011223344, 64'h0000000123456789, {11{64'h0}}}};
    reset = 1'b1; tx_en = 1'b0; lsbfirst = 1'b1; iowidth = 2'd0;
    access_in = 1'b0; packet_in = '0; tx_wait = 1'b0;
    step(2);
    chk("rst_wait_out", wait_out, 0);
    chk("rst_access", tx_access, 0);
    chk("rst_last", tx_last, 0);
    chk("rst_packet", tx_packet, 0);
    chk("rst_full", tx_full, 0);
    chk("rst_prog_full", tx_prog_full, 0);
    chk("rst_empty", tx_empty, 1);
    reset = 1'b0;
    tx_en = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      iowidth = vt[i].iow;
      lsbfirst = vt[i].lsb;
      access_in = 1'b1;
      packet_in = P;
      step();
      access_in = 1'b0;
      chk($sformatf("v%0d_pre_access", i), tx_access, 0);
      chk($sformatf("v%0d_pre_empty", i), tx_empty, 0);
      step();
      for (int k = 0; k < vt[i].n; k++) begin
        chk($sformatf("v%0d_b%0d_access", i, k), tx_access, 1);
        chk($sformatf("v%0d_b%0d_packet", i, k), tx_packet, vt[i].b[k]);
        chk($sformatf("v%0d_b%0d_last", i, k), tx_last, 64'(k == vt[i].n - 1));
        step();
      end
      chk($sformatf("v%0d_post_access", i), tx_access, 0);
      chk($sformatf("v%0d_post_empty", i), tx_empty, 1);
    end
    // fill the buffer with transmission blocked
    tx_en = 1'b0; iowidth = 2'd3; lsbfirst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      access_in = 1'b1;
      packet_in = pk(i);
      step();
      chk($sformatf("fill%0d_wait_out", i), wait_out, 64'(i >= 3));
      chk($sformatf("fill%0d_prog_full", i), tx_prog_full, 64'(i >= 2));
      chk($sformatf("fill%0d_full", i), tx_full, 64'(i >= 3));
      chk($sformatf("fill%0d_access", i), tx_access, 0);
    end
    access_in = 1'b0;
    tx_en = 1'b1;
    step();
    chk("drain_wait_out", wait_out, 0);
    chk("drain_full", tx_full, 0);
    chk("drain_prog_full", tx_prog_full, 1);
    for (int i = 0; i < 4; i++) begin
      q = {24'h0, pk(i)};
      for (int h = 0; h < 2; h++) begin
        chk($sformatf("drain%0d_%0d_access", i, h), tx_access, 1);
        chk($sformatf("drain%0d_%0d_packet", i, h), tx_packet, q[h*64 +: 64]);
        chk($sformatf("drain%0d_%0d_last", i, h), tx_last, 64'(h == 1));
        step();
      end
    end
    chk("drain_done_access", tx_access, 0);
    chk("drain_done_empty", tx_empty, 1);
    // pushback from the IO side freezes a beat
    iowidth = 2'd1; lsbfirst = 1'b1;
    access_in = 1'b1; packet_in = P;
    step();
    access_in = 1'b0;
    step();
    acc = 0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("wt_b%0d_packet", k), tx_packet, vt[3].b[k]);
      chk($sformatf("wt_b%0d_last", k), tx_last, 64'(k == 6));
      acc += int'(tx_access);
      if (k == 2) begin
        fp = tx_packet; fa = tx_access; fl = tx_last;
        tx_wait = 1'b1;
        for (int j = 0; j < 3; j++) begin
          step();
          chk($sformatf("wt_hold%0d_packet", j), tx_packet, fp);
          chk($sformatf("wt_hold%0d_access", j), tx_access, 64'(fa));
          chk($sformatf("wt_hold%0d_last", j), tx_last, 64'(fl));
          acc += int'(tx_access);
        end
        tx_wait = 1'b0;
      end
      step();
    end
    chk("wt_access_cycles", 64'(acc), 10);
    chk("wt_done_access", tx_access, 0);
    // width change mid-packet only affects the following packet
    iowidth = 2'd0; lsbfirst = 1'b1;
    access_in = 1'b1; packet_in = P;
    step(2);
    access_in = 1'b0;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) iowidth = 2'd3;
      chk($sformatf("sw_b%0d_access", k), tx_access, 1);
      chk($sformatf("sw_b%0d_packet", k), tx_packet, vt[0].b[k]);
      chk($sformatf("sw_b%0d_last", k), tx_last, 64'(k == 12));
      step();
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("sw2_b%0d_access", k), tx_access, 1);
      chk($sformatf("sw2_b%0d_packet", k), tx_packet, vt[5].b[k]);
      chk($sformatf("sw2_b%0d_last", k), tx_last, 64'(k == 1));
      step();
    end
    chk("sw_done_access", tx_access, 0);
    // reset in the middle of a packet with two more buffered
    iowidth = 2'd0;
    access_in = 1'b1; packet_in = P;
    step(3);
    access_in = 1'b0;
    step(3);
    chk("mr_b4_access", tx_access, 1);
    chk("mr_b4_packet", tx_packet, vt[0].b[4]);
    chk("mr_b4_empty", tx_empty, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mr_access", tx_access, 0);
    chk("mr_empty", tx_empty, 1);
    chk("mr_wait_out", wait_out, 0);
    chk("mr_last", tx_last, 0);
    chk("mr_packet", tx_packet, 0);
    chk("mr_prog_full", tx_prog_full, 0);
    acc = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      acc += int'(tx_access);
    end
    chk("mr_no_beats", 64'(acc), 0);
    chk("mr_final_empty", tx_empty, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
